// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_mem
// Description : APB completer backed by a DEPTH x 8-bit register memory.
//               Optional wait states are compiled in with APB_SLAVE_WAIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_mem #(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       PSEL,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [8:0] PADDR,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       PSLVERR
);

   localparam logic [8:0] c_depth = 9'(DEPTH);
   localparam logic [3:0] c_wait  = 4'(WAIT_STATES);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t     r_state;
   logic [7:0] r_addr;
   logic [7:0] r_wdata;
   logic       r_write;
   logic [7:0] r_mem [DEPTH];

   logic       w_cnt_zero;
   logic       w_in_range;
   logic       w_we;
   logic [7:0] w_rd_word;
   logic       w_unused_paddr;

   // Bit 8 selects between completers on the requester side only.
   assign w_unused_paddr = PADDR[8];

`ifdef APB_SLAVE_WAIT_EN
   logic [3:0] r_cnt;
   assign w_cnt_zero = (r_cnt == 4'd0);
`else
   logic w_unused_wait;
   assign w_cnt_zero    = 1'b1;
   assign w_unused_wait = |c_wait;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= IDLE;
         r_addr  <= 8'h00;
         r_wdata <= 8'h00;
         r_write <= 1'b0;
`ifdef APB_SLAVE_WAIT_EN
         r_cnt   <= 4'd0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (PSEL && !PENABLE) begin
                  r_state <= ACCESS;
                  r_addr  <= PADDR[7:0];
                  r_wdata <= PWDATA;
                  r_write <= PWRITE;
`ifdef APB_SLAVE_WAIT_EN
                  r_cnt   <= c_wait;
`endif
               end
            end
            ACCESS: begin
               // Losing PSEL/PENABLE mid-transfer is an abort, not a completion.
               if (!(PSEL && PENABLE) || w_cnt_zero) begin
                  r_state <= IDLE;
               end
`ifdef APB_SLAVE_WAIT_EN
               else begin
                  r_cnt <= r_cnt - 4'd1;
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_in_range = ({1'b0, r_addr} < c_depth);
   assign PREADY     = (r_state == ACCESS) && w_cnt_zero && PSEL && PENABLE;
   assign PSLVERR    = PREADY && !w_in_range;
   assign w_we       = PREADY && r_write && w_in_range;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_we && (r_addr == 8'(i))) begin
               r_mem[i] <= r_wdata;
            end
         end
      end
   end

   always_comb begin
      w_rd_word = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_addr == 8'(i)) begin
            w_rd_word = r_mem[i];
         end
      end
   end

   assign PRDATA = (PREADY && !r_write && w_in_range) ? w_rd_word : 8'h00;

endmodule
`default_nettype wire

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 8-bit storage locations, legal range 1..256.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, meaning the PREADY-low cycles inserted per access when the wait feature is compiled in, legal range 0..15.
REQ-003 The block SHALL have port PCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port PRESETn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port PSEL, input, 1 bit: the requester selects this completer.
REQ-006 The block SHALL have port PENABLE, input, 1 bit: APB access phase.
REQ-007 The block SHALL have port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port PADDR, input, 9 bits: byte address; only bits [7:0] are decoded, and bit 8 is ignored (requester-side slave select).
REQ-009 The block SHALL have port PWDATA, input, 8 bits: write data.
REQ-010 The block SHALL have port PRDATA, output, 8 bits: read data.
REQ-011 The block SHALL have port PREADY, output, 1 bit: transfer completes this cycle.
REQ-012 The block SHALL have port PSLVERR, output, 1 bit: the completing transfer failed.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and ACCESS.
REQ-014 In IDLE, a cycle with PSEL=1 and PENABLE=0 is a SETUP cycle; at that edge the block SHALL latch PADDR[7:0], PWRITE and PWDATA, load the wait counter, and move to ACCESS.
REQ-015 In IDLE, PSEL=1 with PENABLE=1 (no setup seen) SHALL be ignored, with no state change and no write.
REQ-016 In ACCESS, with PSEL=1 and PENABLE=1, PREADY SHALL be 0 while the wait counter is non-zero; the counter SHALL decrement by 1 per cycle.
REQ-017 In ACCESS, when the counter equals 0, PREADY SHALL be 1 combinationally from state for exactly one cycle; at that edge the FSM SHALL return to IDLE.
REQ-018 Access latency SHALL be WAIT_STATES+1 ACCESS cycles: with WAIT_STATES=2, PREADY is high in the 3rd cycle after SETUP.
REQ-019 A write SHALL commit latched PWDATA to mem[latched addr] only at the edge where PREADY=1 and PSLVERR=0.
REQ-020 A read SHALL drive PRDATA=mem[latched addr] in the PREADY=1 cycle; at all other times, and on errored reads, PRDATA SHALL be 8'h00.
REQ-021 PSLVERR SHALL be 1 only in the PREADY=1 cycle, and only when the latched address >= DEPTH; out-of-range writes SHALL leave memory unchanged.
REQ-022 If PSEL drops or PENABLE drops during ACCESS, the FSM SHALL abort to IDLE with no write and PREADY/PSLVERR remaining 0.
REQ-023 Back-to-back transfers SHALL be supported: a SETUP in the cycle after PREADY=1 SHALL be accepted with no idle cycle in between.
REQ-024 PSEL=0 in IDLE SHALL hold all state; changes on PADDR, PWDATA or PWRITE during ACCESS SHALL be ignored, because the latched copies are used.

Reset
REQ-025 While PRESETn=0, the block SHALL force: FSM=IDLE, wait counter=0, PREADY=0, PSLVERR=0, PRDATA=8'h00, and all memory locations=8'h00.
REQ-026 Reset asserted mid-ACCESS SHALL abort the transfer immediately with no memory write; the first SETUP after release SHALL be accepted normally.

Configuration
REQ-027 With macro APB_SLAVE_WAIT_EN defined, the wait counter SHALL be loaded with WAIT_STATES at SETUP.
REQ-028 Without APB_SLAVE_WAIT_EN, the counter logic SHALL be absent, and PREADY SHALL be 1 in the first ACCESS cycle (zero wait states) regardless of WAIT_STATES.

Verification
REQ-029 Scenario: write 8'hA5 to 9'h010, then read 9'h010 -> the read returns PRDATA=8'hA5, PSLVERR=0, and PREADY is high in the 3rd ACCESS cycle (WAIT_EN, WAIT_STATES=2).
REQ-030 Scenario: write 8'h3C to 9'h040 (DEPTH=64) -> PSLVERR=1 with PREADY; a subsequent read of 9'h040 -> PRDATA=8'h00, PSLVERR=1.
REQ-031 Scenario: back-to-back writes 8'h11 to 9'h001 and 8'h22 to 9'h002 with no idle cycle, then reads of both -> return 8'h11 and 8'h22.
REQ-032 Scenario: PRESETn pulsed low during ACCESS of a write of 8'hFF to 9'h005 -> PREADY=0 immediately, and a later read of 9'h005 returns 8'h00.
REQ-033 Scenario: PSEL deasserted in the 2nd ACCESS cycle of a write of 8'h77 to 9'h006 -> no PREADY, and a later read of 9'h006 returns 8'h00.
REQ-034 Scenario: build without APB_SLAVE_WAIT_EN and read 9'h000 -> PREADY=1 in the first ACCESS cycle, PRDATA=8'h00.
